// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - round-robin arbiter sharing a banked single-port RAM between requesters
// Optional feature macro: RAM_ARB_WRITE_PROTECT_EN (adds wp_bank_mask input and rsp_err output)
module ram_access_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
`ifdef RAM_ARB_WRITE_PROTECT_EN
    input  logic [3:0]                       wp_bank_mask,
    output logic [NUM_REQ-1:0]               rsp_err,
`endif
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    inout  wire  [DATA_WIDTH-1:0]            ram_data,
    output logic                             ram_cs,
    output logic                             ram_we,
    output logic                             ram_oe
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_ARB_WRITE_PROTECT_EN
    logic [NUM_REQ-1:0]      rsp_err_q, rsp_err_d;
`endif

    logic                    found;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        scan_idx;
    logic [NUM_REQ-1:0]      winner_onehot;
    logic [NUM_REQ-1:0]      owner_onehot;
    logic                    wp_block;
    logic                    drive_en;

    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign owner_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    // Suppress a latched write that targets a protected bank; reads always pass.
`ifdef RAM_ARB_WRITE_PROTECT_EN
    assign wp_block = we_q && wp_bank_mask[addr_q[ADDR_WIDTH-1:ADDR_WIDTH-2]];
`else
    assign wp_block = 1'b0;
`endif

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Grant is combinational and only offered while the sequencer is idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) begin
            req_ready = winner_onehot;
        end
    end

    // Sequencer next-state, request latching and RAM pin control.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_ARB_WRITE_PROTECT_EN
        rsp_err_d   = '0;
`endif
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_addr    = '0;
        drive_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d  = winner;
                    addr_d   = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    we_d     = req_we[winner];
                    wdata_d  = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = addr_q;
                ram_cs   = !wp_block;
                ram_we   = we_q && !wp_block;
                ram_oe   = !we_q;
                drive_en = we_q && !wp_block;
                if (we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = owner_onehot;
`ifdef RAM_ARB_WRITE_PROTECT_EN
                    rsp_err_d   = wp_block ? owner_onehot : '0;
`endif
                end else begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                ram_addr    = addr_q;
                ram_cs      = 1'b1;
                ram_oe      = 1'b1;
                rsp_rdata_d = ram_data;
                rsp_valid_d = owner_onehot;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The controller only ever drives the bus during a permitted write in ACCESS.
    assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef RAM_ARB_WRITE_PROTECT_EN
    assign rsp_err   = rsp_err_q;
`endif

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef RAM_ARB_WRITE_PROTECT_EN
            rsp_err_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_ARB_WRITE_PROTECT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - randomized self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int N  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     ram_addr;
    wire  [DW-1:0]     ram_data;
    logic              ram_cs;
    logic              ram_we;
    logic              ram_oe;
`ifdef RAM_ARB_WRITE_PROTECT_EN
    logic [3:0]        wp_bank_mask;
    logic [N-1:0]      rsp_err;
`endif

    ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef RAM_ARB_WRITE_PROTECT_EN
        .wp_bank_mask (wp_bank_mask),
        .rsp_err      (rsp_err),
`endif
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe)
    );

    always #5 clk = ~clk;

    // Simple RAM device: async read onto the bus when selected and output-enabled.
    logic [DW-1:0] ram_mem [0:65535];
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : {DW{1'bz}};
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    end

    int wr_cycles = 0;
    always @(negedge clk) begin
        if (ram_cs && ram_we) wr_cycles <= wr_cycles + 1;
    end

    // Reference model state: expected pointer and memory contents written so far.
    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_ptr  = 0;
    logic [DW-1:0] exp_mem [int];

    function automatic int model_winner(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_ready(output int who, output bit ok);
        ok  = 1'b0;
        who = -1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (req_ready[i]) who = i;
                break;
            end
            step();
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({req_ready, rsp_valid, ram_cs, ram_we, ram_oe} !== '0)
            $display("FAIL reset_hold: got ready=%b rsp=%b cs/we/oe=%b%b%b expected all 0", req_ready, rsp_valid, ram_cs, ram_we, ram_oe);
        else n_pass++;
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (req_ready !== '0) $display("FAIL idle_ready: got %b expected 0", req_ready); else n_pass++;
        n_checks++;
        if (rsp_valid !== '0) $display("FAIL idle_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++;
        if (rsp_rdata !== '0) $display("FAIL idle_rsp_rdata: got %h expected 0", rsp_rdata); else n_pass++;
        n_checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b000) $display("FAIL idle_ram_ctl: got %b expected 000", {ram_cs, ram_we, ram_oe}); else n_pass++;
        n_checks++;
        if (ram_addr !== '0) $display("FAIL idle_ram_addr: got %h expected 0", ram_addr); else n_pass++;
        exp_ptr = 0;
    endtask

    task automatic test_write_read();
        int who;
        bit ok;
        int wr0;
        wr0 = wr_cycles;
        set_req(0, 1'b1, 16'h4123, 8'hA5);
        wait_ready(who, ok);
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL wr_grant: got %b expected 0001", req_ready); else n_pass++;
        exp_ptr = 1;
        exp_mem[32'h4123] = 8'hA5;
        step();
        n_checks++;
        if ({ram_cs, ram_we, ram_oe, ram_addr} !== {3'b110, 16'h4123})
            $display("FAIL wr_access: got cs/we/oe=%b%b%b addr=%h expected 110 addr=4123", ram_cs, ram_we, ram_oe, ram_addr);
        else n_pass++;
        req_valid[0] = 1'b0;
        step();
        n_checks++;
        if (rsp_valid !== 4'b0001) $display("FAIL wr_rsp_t2: got %b expected 0001", rsp_valid); else n_pass++;
        n_checks++;
        if (wr_cycles - wr0 !== 1) $display("FAIL wr_cs_we_cycles: got %0d expected 1", wr_cycles - wr0); else n_pass++;
        // Issue the read in the same IDLE cycle that carries the write response.
        set_req(0, 1'b0, 16'h4123, 8'h00);
        wait_ready(who, ok);
        n_checks++;
        if ({req_ready, rsp_valid} !== {4'b0001, 4'b0001})
            $display("FAIL rsp_and_grant_overlap: got ready=%b rsp=%b expected 0001/0001", req_ready, rsp_valid);
        else n_pass++;
        exp_ptr = 1;
        step();
        n_checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b101) $display("FAIL rd_access: got %b expected 101", {ram_cs, ram_we, ram_oe}); else n_pass++;
        req_valid[0] = 1'b0;
        step();
        n_checks++;
        if ({ram_cs, ram_we, ram_oe, rsp_valid} !== {3'b101, 4'b0000})
            $display("FAIL rd_wait: got cs/we/oe=%b%b%b rsp=%b expected 101/0000", ram_cs, ram_we, ram_oe, rsp_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0001, exp_mem[32'h4123]})
            $display("FAIL rd_rsp_t3: got rsp=%b data=%h expected 0001/%h", rsp_valid, rsp_rdata, exp_mem[32'h4123]);
        else n_pass++;
        step();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0000, 8'hA5})
            $display("FAIL rd_hold: got rsp=%b data=%h expected 0000/a5", rsp_valid, rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int who;
        bit ok;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom_range(255, 0)), 8'h00);
        for (int k = 0; k < 5; k++) begin
            wait_ready(who, ok);
            n_checks++;
            if (who !== exp_order[k] || who !== model_winner(4'hF, exp_ptr))
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, who, exp_order[k]);
            else n_pass++;
            exp_ptr = (exp_order[k] + 1) % N;
            repeat (3) step();
        end
        clear_reqs();
        repeat (3) step();
    endtask

    task automatic test_pointer_skip();
        int who;
        bit ok;
        pulse_reset();
        set_req(2, 1'b1, 16'h0010, 8'h3C);
        wait_ready(who, ok);
        n_checks++;
        if (who !== 2) $display("FAIL skip_first: got %0d expected 2", who); else n_pass++;
        exp_mem[32'h0010] = 8'h3C;
        exp_ptr = 3;
        step();
        clear_reqs();
        step();
        set_req(1, 1'b0, 16'h0010, 8'h00);
        wait_ready(who, ok);
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL skip_wrap_grant: got %b expected 0010", req_ready); else n_pass++;
        exp_ptr = 2;
        step();
        clear_reqs();
        step();
        step();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0010, 8'h3C}) $display("FAIL skip_rsp: got %b/%h expected 0010/3c", rsp_valid, rsp_rdata); else n_pass++;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0010, 8'h00);
        wait_ready(who, ok);
        n_checks++;
        if (who !== model_winner(4'hF, exp_ptr) || who !== 2) $display("FAIL skip_ptr_after: got %0d expected 2", who); else n_pass++;
        exp_ptr = 3;
        step();
        clear_reqs();
        repeat (3) step();
    endtask

    task automatic test_reset_mid_read();
        int who;
        bit ok;
        bit seen;
        set_req(1, 1'b0, 16'h4123, 8'h00);
        wait_ready(who, ok);
        step();
        clear_reqs();
        step();
        n_checks++;
        if ({ram_cs, ram_oe} !== 2'b11) $display("FAIL mid_read_state: got cs/oe=%b%b expected 11", ram_cs, ram_oe); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_cs, ram_we, ram_oe, ram_addr, rsp_rdata, rsp_valid} !== '0)
            $display("FAIL mid_read_async_clear: got cs/we/oe=%b%b%b addr=%h rdata=%h rsp=%b expected 0", ram_cs, ram_we, ram_oe, ram_addr, rsp_rdata, rsp_valid);
        else n_pass++;
        step();
        rst_n = 1'b1;
        exp_ptr = 0;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (rsp_valid != '0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL mid_read_no_rsp: got %b expected 0", seen); else n_pass++;
        set_req(3, 1'b1, 16'h0042, 8'h5C);
        wait_ready(who, ok);
        n_checks++;
        if (who !== 3) $display("FAIL post_reset_grant: got %0d expected 3", who); else n_pass++;
        exp_mem[32'h0042] = 8'h5C;
        exp_ptr = 0;
        step();
        clear_reqs();
        step();
        n_checks++;
        if (rsp_valid !== 4'b1000) $display("FAIL post_reset_rsp: got %b expected 1000", rsp_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        logic          f_we   [N];
        logic [AW-1:0] f_addr [N];
        logic [DW-1:0] f_data [N];
        int who;
        int exp_w;
        int lat;
        bit ok;
        pend = '0;
        clear_reqs();
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i]   = 1'b1;
                    f_we[i]   = 1'($urandom_range(1, 0));
                    f_addr[i] = {2'($urandom_range(3, 0)), 14'($urandom_range(15, 0))};
                    f_data[i] = 8'($urandom_range(255, 0));
                end
            end
            if (pend == '0) begin
                exp_w = int'($urandom_range(N - 1, 0));
                pend[exp_w]   = 1'b1;
                f_we[exp_w]   = 1'b0;
                f_addr[exp_w] = 16'h0042;
                f_data[exp_w] = 8'h00;
            end
            for (int i = 0; i < N; i++) if (pend[i]) set_req(i, f_we[i], f_addr[i], f_data[i]);
            exp_w = model_winner(pend, exp_ptr);
            wait_ready(who, ok);
            n_checks++;
            if (who !== exp_w) $display("FAIL rand_grant[%0d]: got %0d expected %0d pend=%b", it, who, exp_w, pend); else n_pass++;
            exp_ptr = (exp_w + 1) % N;
            step();
            n_checks++;
            if ({ram_cs, ram_we, ram_addr} !== {1'b1, f_we[exp_w], f_addr[exp_w]})
                $display("FAIL rand_access[%0d]: got cs=%b we=%b addr=%h expected 1/%b/%h", it, ram_cs, ram_we, ram_addr, f_we[exp_w], f_addr[exp_w]);
            else n_pass++;
            pend[exp_w]      = 1'b0;
            req_valid[exp_w] = 1'b0;
            lat = 1;
            while (rsp_valid == '0 && lat < 6) begin
                step();
                lat++;
            end
            n_checks++;
            if (lat !== (f_we[exp_w] ? 2 : 3) || rsp_valid !== (N'(1) << exp_w))
                $display("FAIL rand_rsp[%0d]: got lat=%0d rsp=%b expected lat=%0d rsp=%b", it, lat, rsp_valid, f_we[exp_w] ? 2 : 3, N'(1) << exp_w);
            else n_pass++;
            if (f_we[exp_w]) begin
                exp_mem[int'(f_addr[exp_w])] = f_data[exp_w];
            end else if (exp_mem.exists(int'(f_addr[exp_w]))) begin
                n_checks++;
                if (rsp_rdata !== exp_mem[int'(f_addr[exp_w])])
                    $display("FAIL rand_rdata[%0d]: got %h expected %h addr=%h", it, rsp_rdata, exp_mem[int'(f_addr[exp_w])], f_addr[exp_w]);
                else n_pass++;
            end
        end
        clear_reqs();
        repeat (3) step();
    endtask

`ifdef RAM_ARB_WRITE_PROTECT_EN
    task automatic test_write_protect();
        int who;
        bit ok;
        wp_bank_mask = 4'b0000;
        set_req(0, 1'b1, 16'h8001, 8'h11);
        wait_ready(who, ok);
        step();
        clear_reqs();
        step();
        exp_mem[32'h8001] = 8'h11;
        wp_bank_mask = 4'b0100;
        set_req(0, 1'b1, 16'h8001, 8'h22);
        wait_ready(who, ok);
        step();
        n_checks++;
        if ({ram_cs, ram_we} !== 2'b00) $display("FAIL wp_suppress: got cs/we=%b%b expected 00", ram_cs, ram_we); else n_pass++;
        clear_reqs();
        step();
        n_checks++;
        if ({rsp_valid, rsp_err} !== {4'b0001, 4'b0001}) $display("FAIL wp_err: got rsp=%b err=%b expected 0001/0001", rsp_valid, rsp_err); else n_pass++;
        set_req(0, 1'b0, 16'h8001, 8'h00);
        wait_ready(who, ok);
        step();
        clear_reqs();
        step();
        step();
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 4'b0000, exp_mem[32'h8001]})
            $display("FAIL wp_read_old: got rsp=%b err=%b data=%h expected 0001/0000/%h", rsp_valid, rsp_err, rsp_rdata, exp_mem[32'h8001]);
        else n_pass++;
        wp_bank_mask = 4'b0000;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear_reqs();
`ifdef RAM_ARB_WRITE_PROTECT_EN
        wp_bank_mask = 4'b0000;
`endif
        test_reset();
        test_write_read();
        test_round_robin();
        test_pointer_skip();
        test_reset_mid_read();
        test_random();
`ifdef RAM_ARB_WRITE_PROTECT_EN
        test_write_protect();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
